// File: rtl/stack_sequencer.sv
// Issues a stored program of stack operations one instruction at a time.
// Each instruction takes an ISSUE cycle and a SAMPLE cycle, and the run stops early on stack overflow.
//
// state  | meaning
// IDLE   | waiting for start; program memory writable
// ISSUE  | drive mem[pc] to the stack for one cycle
// SAMPLE | opcode back to no-op; check overflow / end of program
// DONE   | one-cycle completion pulse
module stack_sequencer #(
  parameter int N     = 32,
  parameter int DEPTH = 16,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          prog_we,
  input  logic [AW-1:0] prog_addr,
  input  logic [2:0]    prog_opcode,
  input  logic [N-1:0]  prog_data,
  input  logic [AW:0]   len,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic [N-1:0]  result,
  output logic          err,
  output logic [AW-1:0] err_pc,
  output logic [2:0]    stk_opcode,
  output logic [N-1:0]  stk_in,
  input  logic [N-1:0]  stk_out,
  input  logic          stk_overflow
);

  typedef enum logic [1:0] {IDLE, ISSUE, SAMPLE, DONE} state_t;

  state_t        state_q, state_d;
  logic [2:0]    mem_op  [DEPTH];
  logic [N-1:0]  mem_dat [DEPTH];
  logic [AW-1:0] pc_q;
  logic [AW:0]   len_q;
  logic [N-1:0]  in_q;
  logic          last_instr;

  assign last_instr = ({1'b0, pc_q} == (len_q - (AW+1)'(1)));

  // Program memory has no reset so a loaded program survives rst.
  always_ff @(posedge clk) begin
    if (prog_we && state_q == IDLE) begin
      mem_op[prog_addr]  <= prog_opcode;
      mem_dat[prog_addr] <= prog_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = (len == '0) ? DONE : ISSUE;
      ISSUE:   state_d = SAMPLE;
      SAMPLE:  state_d = (stk_overflow || last_instr) ? DONE : ISSUE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q   <= '0;
      len_q  <= '0;
      in_q   <= '0;
      busy   <= 1'b0;
      result <= '0;
      err    <= 1'b0;
      err_pc <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            err    <= 1'b0;
            err_pc <= '0;
            if (len != '0) begin
              len_q <= len;
              pc_q  <= '0;
              busy  <= 1'b1;
            end else begin
              result <= '0;
            end
          end
        end
        ISSUE: in_q <= mem_dat[pc_q];
        SAMPLE: begin
          if (stk_overflow) begin
            err    <= 1'b1;
            err_pc <= pc_q;
            result <= stk_out;
          end else if (last_instr) begin
            result <= stk_out;
          end else begin
            pc_q <= pc_q + AW'(1);
          end
        end
        DONE:    busy <= 1'b0;
        default: ;
      endcase
    end
  end

  // stk_in stays on the issued operand through SAMPLE and afterwards.
  assign stk_opcode = (state_q == ISSUE) ? mem_op[pc_q]  : 3'd0;
  assign stk_in     = (state_q == ISSUE) ? mem_dat[pc_q] : in_q;
  assign done       = (state_q == DONE);

endmodule

// File: tb/tb_stack_sequencer.sv
// Self-checking bench for stack_sequencer: a stub stack plus a reference model
// that predicts the issued opcode/operand stream and the completion cycle.
module tb_stack_sequencer;
  localparam int N = 32;
  localparam int DEPTH = 16;
  localparam int AW = 4;

  logic          clk = 0;
  logic          rst = 1;
  logic          prog_we = 0;
  logic [AW-1:0] prog_addr = '0;
  logic [2:0]    prog_opcode = '0;
  logic [N-1:0]  prog_data = '0;
  logic [AW:0]   len = '0;
  logic          start = 0;
  logic          busy, done, err;
  logic [N-1:0]  result, stk_in;
  logic [AW-1:0] err_pc;
  logic [2:0]    stk_opcode;
  logic [N-1:0]  stk_out = '0;
  logic          stk_overflow = 0;

  logic [2:0]   m_op  [DEPTH];
  logic [N-1:0] m_dat [DEPTH];

  int n_checks = 0;
  int n_fail = 0;

  stack_sequencer #(.N(N), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .prog_we(prog_we), .prog_addr(prog_addr),
    .prog_opcode(prog_opcode), .prog_data(prog_data), .len(len), .start(start),
    .busy(busy), .done(done), .result(result), .err(err), .err_pc(err_pc),
    .stk_opcode(stk_opcode), .stk_in(stk_in), .stk_out(stk_out),
    .stk_overflow(stk_overflow)
  );

  always #5 clk = ~clk;

  task automatic load(input int a, input logic [2:0] op, input logic [N-1:0] d);
    prog_we = 1; prog_addr = AW'(a); prog_opcode = op; prog_data = d;
    m_op[a] = op; m_dat[a] = d;
    @(posedge clk); #1;
    prog_we = 0;
  endtask

  // ovf: index whose SAMPLE reports overflow (-1 = none); poke: cycle in which a
  // write+start is attempted mid-run (0 = none); wr0: write entry 0 together with start.
  task automatic run(input int L, input int ovf, input logic [N-1:0] sout,
                     input int poke, input bit wr0, input logic [2:0] w_op,
                     input logic [N-1:0] w_dat);
    int last, total, idx;
    logic [2:0] e_op;
    logic [N-1:0] e_in;
    bit ovf_hit;
    ovf_hit = (ovf >= 0 && ovf < L);
    last = ovf_hit ? ovf : L - 1;
    total = (L == 0) ? 1 : 2 * (last + 1) + 1;
    stk_out = sout;
    len = (AW+1)'(L); start = 1;
    if (wr0) begin
      prog_we = 1; prog_addr = '0; prog_opcode = w_op; prog_data = w_dat;
      m_op[0] = w_op; m_dat[0] = w_dat;
    end
    @(posedge clk); #1;
    start = 0; prog_we = 0; len = (AW+1)'($urandom_range(0, DEPTH));
    for (int cyc = 1; cyc <= total; cyc++) begin
      stk_overflow = ovf_hit && (cyc == 2 * ovf + 2);
      if (cyc == poke) begin
        prog_we = 1; prog_addr = '0; prog_opcode = 3'($urandom); prog_data = $urandom;
        start = 1; len = (AW+1)'($urandom_range(1, DEPTH));
      end else begin
        prog_we = 0; start = 0;
      end
      @(negedge clk);
      if (cyc < total) begin
        idx = (cyc - 1) / 2;
        e_op = (cyc % 2 == 1) ? m_op[idx] : 3'd0;
        e_in = m_dat[idx];
      end else begin
        e_op = 3'd0;
        e_in = (L > 0) ? m_dat[last] : stk_in;
      end
      if (stk_opcode !== e_op) begin
        n_fail++; $display("FAIL stk_opcode L=%0d cyc=%0d got %0d want %0d", L, cyc, stk_opcode, e_op);
      end
      n_checks++;
      if (L > 0) begin
        if (stk_in !== e_in) begin
          n_fail++; $display("FAIL stk_in L=%0d cyc=%0d got %h want %h", L, cyc, stk_in, e_in);
        end
        n_checks++;
      end
      if (done !== (cyc == total)) begin
        n_fail++; $display("FAIL done L=%0d cyc=%0d got %b want %b", L, cyc, done, cyc == total);
      end
      n_checks++;
      if (busy !== (L > 0)) begin
        n_fail++; $display("FAIL busy L=%0d cyc=%0d got %b want %b", L, cyc, busy, L > 0);
      end
      n_checks++;
      @(posedge clk); #1;
    end
    stk_overflow = 0; prog_we = 0; start = 0;
    @(negedge clk);
    if (done !== 1'b0 || busy !== 1'b0 || stk_opcode !== 3'd0) begin
      n_fail++; $display("FAIL idle_after L=%0d got done=%b busy=%b op=%0d want 0 0 0", L, done, busy, stk_opcode);
    end
    n_checks++;
    if (result !== ((L == 0) ? '0 : sout)) begin
      n_fail++; $display("FAIL result L=%0d got %h want %h", L, result, (L == 0) ? '0 : sout);
    end
    n_checks++;
    if (err !== ovf_hit) begin
      n_fail++; $display("FAIL err L=%0d got %b want %b", L, err, ovf_hit);
    end
    n_checks++;
    if (err_pc !== (ovf_hit ? AW'(ovf) : AW'(0))) begin
      n_fail++; $display("FAIL err_pc L=%0d got %0d want %0d", L, err_pc, ovf_hit ? ovf : 0);
    end
    n_checks++;
    @(posedge clk); #1;
  endtask

  task automatic check_reset_vals(input string tag);
    if (busy !== 0 || done !== 0 || result !== '0 || err !== 0 || err_pc !== '0 ||
        stk_opcode !== 3'd0 || stk_in !== '0) begin
      n_fail++;
      $display("FAIL %s got busy=%b done=%b result=%h err=%b err_pc=%0d op=%0d in=%h want all zero",
               tag, busy, done, result, err, err_pc, stk_opcode, stk_in);
    end
    n_checks++;
  endtask

  task automatic test_reset();
    rst = 1;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    check_reset_vals("reset_state");
    @(posedge clk); #1;
    rst = 0;
  endtask

  task automatic load_ref_prog();
    load(0, 3'd6, 32'd1);
    load(1, 3'd6, 32'd2);
    load(2, 3'd6, -32'sd30000000);
    load(3, 3'd6, 32'd4000000);
    load(4, 3'd6, 32'd5);
    load(5, 3'd7, 32'd0);
    load(6, 3'd4, 32'd0);
    load(7, 3'd5, 32'd0);
    load(8, 3'd4, 32'd0);
  endtask

  task automatic test_ref_program();
    load_ref_prog();
    run(9, -1, 32'h1234, 0, 0, 3'd0, '0);
  endtask

  task automatic test_overflow();
    run(9, 7, 32'h1234, 0, 0, 3'd0, '0);
  endtask

  task automatic test_zero_len();
    run(0, -1, 32'h5555, 0, 0, 3'd0, '0);
  endtask

  task automatic test_reset_mid_run();
    bit saw_done;
    len = 5'd9; start = 1;
    @(posedge clk); #1;
    start = 0;
    repeat (7) begin @(posedge clk); #1; end
    rst = 1;
    @(posedge clk); #1;
    @(negedge clk);
    check_reset_vals("reset_mid_run");
    @(posedge clk); #1;
    rst = 0;
    saw_done = 0;
    repeat (4) begin @(negedge clk); saw_done |= done; @(posedge clk); #1; end
    if (saw_done !== 1'b0) begin
      n_fail++; $display("FAIL no_done_after_reset got %b want 0", saw_done);
    end
    n_checks++;
    run(9, -1, 32'hCAFE, 0, 0, 3'd0, '0);
  endtask

  task automatic test_write_while_busy();
    run(9, -1, 32'hBEEF, 3, 0, 3'd0, '0);
    run(9, -1, 32'hBEF0, 0, 0, 3'd0, '0);
  endtask

  task automatic test_write_with_start();
    run(5, -1, 32'h77, 0, 1, 3'd2, 32'hA5A5_0F0F);
  endtask

  task automatic test_random();
    for (int t = 0; t < 8; t++) begin
      int L, ov;
      for (int a = 0; a < DEPTH; a++) load(a, 3'($urandom), $urandom);
      L = $urandom_range(1, DEPTH);
      ov = ($urandom_range(0, 2) == 0) ? -1 : $urandom_range(0, L - 1);
      run(L, ov, $urandom, 0, 0, 3'd0, '0);
    end
  endtask

  initial begin
    test_reset();
    test_ref_program();
    test_overflow();
    test_zero_len();
    test_reset_mid_run();
    test_write_while_busy();
    test_write_with_start();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/stack_sequencer.md
STACK_SEQUENCER -- requirements
Module: stack_sequencer

Interface
REQ-001 SHALL have parameter N, default 32, giving the stack data width in bits.
REQ-002 SHALL have parameter DEPTH, default 16, giving the program memory entries (power of two; address width AW = log2(DEPTH)).
REQ-003 clk  in  1  sole clock; all state updates on rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 prog_we  in  1  program-memory write enable.
REQ-006 prog_addr  in  AW  program-memory write address.
REQ-007 prog_opcode  in  3  instruction opcode to store.
REQ-008 prog_data  in  N  instruction operand to store, used by push only.
REQ-009 len  in  AW+1  program length 0..DEPTH, sampled with start.
REQ-010 start  in  1  run request, single-cycle.
REQ-011 busy  out  1  high from first ISSUE through DONE.
REQ-012 done  out  1  one-cycle completion pulse.
REQ-013 result  out  N  stk_out captured after the last instruction.
REQ-014 err  out  1  overflow seen during the run; sticky until next accepted start.
REQ-015 err_pc  out  AW  index of the instruction that overflowed.
REQ-016 stk_opcode  out  3  opcode to the stack (4 add, 5 mul, 6 push, 7 pop, 0-3 no-op).
REQ-017 stk_in  out  N  operand to the stack.
REQ-018 stk_out  in  N  stack top from the stack.
REQ-019 stk_overflow  in  1  overflow flag from the stack.

Function
REQ-020 SHALL store {opcode, operand} at prog_addr on a clock edge when prog_we=1 and state is IDLE; writes in any other state SHALL be ignored.
REQ-021 SHALL implement the FSM states IDLE, ISSUE, SAMPLE and DONE.
REQ-022 IDLE: start=1 with len>0 SHALL latch len, set pc=0, clear err and err_pc, and go to ISSUE; start=1 with len=0 SHALL go to DONE with result=0 and err=0.
REQ-023 ISSUE SHALL drive stk_opcode=mem[pc].opcode and stk_in=mem[pc].operand for exactly one cycle, then go to SAMPLE.
REQ-024 SAMPLE SHALL drive stk_opcode=0 with stk_in held, so that consecutive identical opcodes are distinct events to the stack.
REQ-025 In SAMPLE with stk_overflow=1, the block SHALL set err=1, set err_pc=pc, capture result=stk_out, and go to DONE.
REQ-026 In SAMPLE with no overflow and pc=len-1, the block SHALL capture result=stk_out and go to DONE.
REQ-027 In SAMPLE with no overflow and pc<len-1, the block SHALL increment pc and go to ISSUE.
REQ-028 DONE SHALL assert done=1 for one cycle and return to IDLE; result, err and err_pc SHALL hold until the next accepted start.
REQ-029 For len=L with no overflow, done SHALL be high in cycle 2L+1 after the edge that sampled start.
REQ-030 start while not IDLE SHALL be ignored.
REQ-031 Opcodes 0-3 in memory SHALL be issued unchanged and SHALL take the same two cycles.
REQ-032 prog_we and start in the same IDLE cycle: the write SHALL complete and be visible to the run.
REQ-033 stk_opcode SHALL be 0 in IDLE and DONE; stk_in SHALL hold its last value.

Reset
REQ-034 rst=1 SHALL force state=IDLE, pc=0, busy=0, done=0, result=0, err=0, err_pc=0, stk_opcode=0, stk_in=0, overriding any state mid-run.
REQ-035 Program memory contents SHALL be unaffected by rst.

Verification
REQ-036 Load push 1, push 2, push -30000000, push 4000000, push 5, pop, add, mul, add (len=9), using a stub stack with stk_out=32'h1234 and stk_overflow=0 -> stk_opcode sequence 6,0,6,0,6,0,6,0,6,0,7,0,4,0,5,0,4,0; stk_in values 1, 2, -30000000, 4000000, 5 on the push cycles; done in cycle 19; result=32'h1234; err=0.
REQ-037 Same program with stub stk_overflow=1 during the SAMPLE of pc=7 -> done one cycle later, err=1, err_pc=7, no opcode 4 issued afterwards.
REQ-038 start with len=0 -> done in cycle 1, result=0, busy never high.
REQ-039 Assert rst during the SAMPLE of pc=3 -> next cycle IDLE, all outputs at reset values, no done pulse; a subsequent start reruns from pc=0.
REQ-040 prog_we and start together while busy -> memory unchanged, run unaffected; prog_we and start together in IDLE with prog_addr=0 -> first ISSUE drives the new entry.
